// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//
// Transmit side of the tile operand interface. Holds one pass of left and top
// operands and streams them into the systolic array with a diagonal skew
// (stream k delayed by k cycles). Zeros fill the unused slots. After the
// operands, DRAIN_CYCLES zero cycles flush the array. A one-cycle row-done
// strobe follows, plus compute-done when the pass was flagged as the last.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   wr_en/wr_sel     operand write strobe; wr_sel 0 = left buffer, 1 = top
//   wr_row/wr_col    stream index k / element index j (out-of-range dropped)
//   wr_data          one element, lane l at [l*DATA_WIDTH +: DATA_WIDTH]
//   wr_ready         write accepted this cycle (idle and no start pending)
//   start/last_pass  begin a pass; last_pass is captured together with start
//   busy             pass in progress (STREAM, DRAIN, DONE)
//   left_out/top_out skewed operand streams, stream k lane l at
//                    [(k*LANES+l)*DATA_WIDTH +: DATA_WIDTH]
//   enable           CCU enable, high while streaming and draining
//   is_row_done      one-cycle pulse at the end of every pass
//   is_compute_done  one-cycle pulse at the end of the final pass
// -----------------------------------------------------------------------------
module systolic_feeder #(
  parameter int MATRIX_SIZE  = 3,
  parameter int ARRAY_SIZE   = 2*MATRIX_SIZE-1,
  parameter int LANES        = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int DRAIN_CYCLES = ARRAY_SIZE
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wr_en,
  input  logic                                   wr_sel,
  input  logic [$clog2(ARRAY_SIZE)-1:0]          wr_row,
  input  logic [$clog2(MATRIX_SIZE)-1:0]         wr_col,
  input  logic [LANES*DATA_WIDTH-1:0]            wr_data,
  output logic                                   wr_ready,
  input  logic                                   start,
  input  logic                                   last_pass,
  output logic                                   busy,
  output logic [ARRAY_SIZE*LANES*DATA_WIDTH-1:0] left_out,
  output logic [ARRAY_SIZE*LANES*DATA_WIDTH-1:0] top_out,
  output logic                                   enable,
  output logic                                   is_row_done,
  output logic                                   is_compute_done
);

  localparam int ELEM_W  = LANES*DATA_WIDTH;
  localparam int VEC_W   = ARRAY_SIZE*ELEM_W;
  localparam int T_LEN   = MATRIX_SIZE + ARRAY_SIZE - 1;
  localparam int CNT_MAX = (T_LEN > DRAIN_CYCLES) ? T_LEN : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               last_q;

  logic [ELEM_W-1:0]  left_buf [ARRAY_SIZE][MATRIX_SIZE];
  logic [ELEM_W-1:0]  top_buf  [ARRAY_SIZE][MATRIX_SIZE];

  logic [VEC_W-1:0]   left_nxt;
  logic [VEC_W-1:0]   top_nxt;
  int                 t_nxt;

  assign wr_ready = (state == IDLE) && !start;

  // Skewed stream contents for the t being entered at the next edge:
  // from IDLE that is t=0, from STREAM it is cnt+1.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    left_nxt = '0;
    top_nxt  = '0;
    t_nxt    = (state == IDLE) ? 0 : int'(cnt) + 1;
    for (int k = 0; k < ARRAY_SIZE; k++) begin
      for (int j = 0; j < MATRIX_SIZE; j++) begin
        if (t_nxt == k + j) begin
          left_nxt[k*ELEM_W +: ELEM_W] = left_buf[k][j];
          top_nxt[k*ELEM_W +: ELEM_W]  = top_buf[k][j];
        end
      end
    end
  end

  // Operand buffers. Writes only land while idle, so streaming never races a
  // write and replays see exactly what was loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the buffers are deliberately cleared on reset so that a pass
      // started after reset streams zeros; this costs a reset on every
      // storage bit and is not something to copy for plain RAMs.
      for (int k = 0; k < ARRAY_SIZE; k++) begin
        for (int j = 0; j < MATRIX_SIZE; j++) begin
          left_buf[k][j] <= '0;
          top_buf[k][j]  <= '0;
        end
      end
    end else if (wr_en && wr_ready &&
                 int'(wr_row) < ARRAY_SIZE && int'(wr_col) < MATRIX_SIZE) begin
      if (wr_sel) top_buf[wr_row][wr_col]  <= wr_data;
      else        left_buf[wr_row][wr_col] <= wr_data;
    end
  end

  // Sequencer with registered outputs: each transition also loads the output
  // values belonging to the state being entered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      last_q          <= 1'b0;
      left_out        <= '0;
      top_out         <= '0;
      enable          <= 1'b0;
      busy            <= 1'b0;
      is_row_done     <= 1'b0;
      is_compute_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= STREAM;
            cnt      <= '0;
            last_q   <= last_pass;
            left_out <= left_nxt;
            top_out  <= top_nxt;
            enable   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        STREAM: begin
          if (cnt == CNT_W'(T_LEN - 1)) begin
            state    <= DRAIN;
            cnt      <= '0;
            left_out <= '0;
            top_out  <= '0;
          end else begin
            cnt      <= cnt + 1'b1;
            left_out <= left_nxt;
            top_out  <= top_nxt;
          end
        end
        DRAIN: begin
          if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
            state           <= DONE;
            cnt             <= '0;
            enable          <= 1'b0;
            is_row_done     <= 1'b1;
            is_compute_done <= last_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state           <= IDLE;
          busy            <= 1'b0;
          is_row_done     <= 1'b0;
          is_compute_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
